// File: rtl/dtmf_pkg.sv
// rtl/dtmf_pkg.sv - shared DTMF frequency table, state encoding and ms timebase helpers
package dtmf_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int ROW_HZ [4] = '{697, 770, 852, 941};
    localparam int COL_HZ [4] = '{1209, 1336, 1477, 1633};
    localparam int MS_PER_S   = 1000;

    // round(clk_hz / (2 * freq_hz)) in integer arithmetic
    function automatic int half_period(input int clk_hz, input int freq_hz);
        return (clk_hz + freq_hz) / (2 * freq_hz);
    endfunction

    function automatic int ms_div(input int clk_hz);
        return clk_hz / MS_PER_S;
    endfunction

endpackage

// File: rtl/dtmf_tone_gen.sv
// rtl/dtmf_tone_gen.sv - square-wave generator toggling every i_half enabled cycles
module dtmf_tone_gen #(
    parameter int W = 10
) (
    input  logic         inclk,
    input  logic         rst_n,
    input  logic [W-1:0] i_half,
    input  logic         i_en,
    input  logic         i_clr,
    output logic         o_wave
);

    logic [W-1:0] r_cnt;
    logic         r_wave;

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (i_en) begin
            if (r_cnt == i_half - W'(1)) begin
                r_cnt  <= '0;
                r_wave <= ~r_wave;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign o_wave = r_wave;

endmodule

// File: rtl/dtmf_tone_sequencer.sv
// rtl/dtmf_tone_sequencer.sv - plays one DTMF digit per handshake: timed tone burst then silence
module dtmf_tone_sequencer
    import dtmf_pkg::*;
#(
    parameter int CLK_HZ  = 1000000,
    parameter int TONE_MS = 100,
    parameter int GAP_MS  = 50
) (
    input  logic       inclk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    output logic       digit_ready,
    input  logic       abort,
    output logic       row_tone,
    output logic       col_tone,
    output logic       busy,
    output logic       done
);

    localparam int MS_DIV = ms_div(CLK_HZ);
    localparam int MS_W   = $clog2(MS_DIV + 1);
    localparam int HP_W   = $clog2(half_period(CLK_HZ, ROW_HZ[0]) + 1);

    localparam logic [HP_W-1:0] ROW_HALF [4] = '{
        HP_W'(half_period(CLK_HZ, ROW_HZ[0])), HP_W'(half_period(CLK_HZ, ROW_HZ[1])),
        HP_W'(half_period(CLK_HZ, ROW_HZ[2])), HP_W'(half_period(CLK_HZ, ROW_HZ[3]))};
    localparam logic [HP_W-1:0] COL_HALF [4] = '{
        HP_W'(half_period(CLK_HZ, COL_HZ[0])), HP_W'(half_period(CLK_HZ, COL_HZ[1])),
        HP_W'(half_period(CLK_HZ, COL_HZ[2])), HP_W'(half_period(CLK_HZ, COL_HZ[3]))};

    localparam logic [MS_W-1:0] MS_LAST   = MS_W'(MS_DIV - 1);
    localparam logic [9:0]      TONE_LAST = 10'(TONE_MS - 1);
    localparam logic [9:0]      GAP_LAST  = 10'(GAP_MS - 1);

    state_t          r_state;
    logic [3:0]      r_digit;
    logic [MS_W-1:0] r_ms_cnt;
    logic [9:0]      r_ms_num;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;

    logic            w_ms_tick;
    logic            w_phase_end;
    logic            w_accept;
    logic            w_tone_run;
    logic [HP_W-1:0] w_row_half;
    logic [HP_W-1:0] w_col_half;

    assign w_ms_tick   = (r_ms_cnt == MS_LAST);
    assign w_phase_end = w_ms_tick && (r_ms_num == ((r_state == S_GAP) ? GAP_LAST : TONE_LAST));
    assign w_accept    = digit_valid && r_ready && !abort;
    // Generators stop on the same edge TONE ends, so GAP and IDLE start silent
    assign w_tone_run  = (r_state == S_TONE) && !abort && !w_phase_end;
    assign w_row_half  = ROW_HALF[r_digit[3:2]];
    assign w_col_half  = COL_HALF[r_digit[1:0]];

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_digit  <= '0;
            r_ms_cnt <= '0;
            r_ms_num <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready  <= 1'b1;
                    r_ms_cnt <= '0;
                    r_ms_num <= '0;
                    if (w_accept) begin
                        r_digit <= digit;
                        r_state <= S_TONE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_TONE, S_GAP: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_ms_cnt <= '0;
                        r_ms_num <= '0;
                    end else if (w_phase_end) begin
                        r_ms_cnt <= '0;
                        r_ms_num <= '0;
                        if (r_state == S_TONE) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_ms_tick) begin
                        r_ms_cnt <= '0;
                        r_ms_num <= r_ms_num + 10'd1;
                    end else begin
                        r_ms_cnt <= r_ms_cnt + MS_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    dtmf_tone_gen #(.W(HP_W)) u_row_gen (
        .inclk  (inclk),
        .rst_n  (rst_n),
        .i_half (w_row_half),
        .i_en   (w_tone_run),
        .i_clr  (!w_tone_run),
        .o_wave (row_tone)
    );

    dtmf_tone_gen #(.W(HP_W)) u_col_gen (
        .inclk  (inclk),
        .rst_n  (rst_n),
        .i_half (w_col_half),
        .i_en   (w_tone_run),
        .i_clr  (!w_tone_run),
        .o_wave (col_tone)
    );

    assign digit_ready = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_dtmf_tone_sequencer.sv
// tb/tb_dtmf_tone_sequencer.sv - scoreboard bench: planned output edge times versus observed edges
module tb_dtmf_tone_sequencer;

    localparam int T = 4000;
    localparam int G = 2000;

    logic       inclk = 1'b0;
    logic       rst_n;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       abort;
    logic       row_tone;
    logic       col_tone;
    logic       busy;
    logic       done;

    int ROW_H [4] = '{717, 649, 587, 531};
    int COL_H [4] = '{414, 374, 339, 306};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    int exp_row [$];
    int exp_col [$];
    int exp_busy [$];
    int exp_done [$];
    logic p_row = 1'b0, p_col = 1'b0, p_busy = 1'b0, p_done = 1'b0;
    int a;
    int a2;

    dtmf_tone_sequencer #(.CLK_HZ(1000000), .TONE_MS(4), .GAP_MS(2)) dut (
        .inclk       (inclk),
        .rst_n       (rst_n),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .abort       (abort),
        .row_tone    (row_tone),
        .col_tone    (col_tone),
        .busy        (busy),
        .done        (done)
    );

    always #5 inclk = ~inclk;
    always @(posedge inclk) cyc++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge inclk);
        #1;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    // mode 0: full sequence, 1: abort at tend, 2: reset at tend (end edges checked directly)
    task automatic plan(input int acc, input logic [3:0] d, input int tend, input int mode);
        int h;
        int n;
        for (int s = 0; s < 2; s++) begin
            h = (s == 0) ? ROW_H[d[3:2]] : COL_H[d[1:0]];
            n = 0;
            for (int t = acc + h; t < tend; t += h) begin
                if (s == 0) exp_row.push_back(t); else exp_col.push_back(t);
                n++;
            end
            if (mode != 2 && (n % 2) == 1) begin
                if (s == 0) exp_row.push_back(tend); else exp_col.push_back(tend);
            end
        end
        exp_busy.push_back(acc);
        if (mode == 0) begin
            exp_busy.push_back(acc + T + G);
            exp_done.push_back(acc + T + G);
            exp_done.push_back(acc + T + G + 1);
        end else if (mode == 1) begin
            exp_busy.push_back(tend);
        end
    endtask

    task automatic queues_empty(input string tag);
        check({tag, "_row_pending"}, exp_row.size(), 0);
        check({tag, "_col_pending"}, exp_col.size(), 0);
        check({tag, "_busy_pending"}, exp_busy.size(), 0);
        check({tag, "_done_pending"}, exp_done.size(), 0);
    endtask

    always @(negedge inclk) begin
        if (mon_en) begin
            if (row_tone !== p_row) begin
                if (exp_row.size() == 0) check("row_extra_edge", cyc, -1);
                else check("row_edge", cyc, exp_row.pop_front());
            end
            if (col_tone !== p_col) begin
                if (exp_col.size() == 0) check("col_extra_edge", cyc, -1);
                else check("col_edge", cyc, exp_col.pop_front());
            end
            if (busy !== p_busy) begin
                if (exp_busy.size() == 0) check("busy_extra_edge", cyc, -1);
                else check("busy_edge", cyc, exp_busy.pop_front());
            end
            if (done !== p_done) begin
                if (exp_done.size() == 0) check("done_extra_edge", cyc, -1);
                else check("done_edge", cyc, exp_done.pop_front());
            end
        end
        p_row  = row_tone;
        p_col  = col_tone;
        p_busy = busy;
        p_done = done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; digit = 4'b0000; digit_valid = 1'b0; abort = 1'b0;
        step(); step(); step();
        check("rst_ready", int'(digit_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tones", int'({row_tone, col_tone}), 0);
        rst_n = 1'b1;
        #1 check("release_ready_pre_edge", int'(digit_ready), 0);
        step();
        check("release_ready", int'(digit_ready), 1);
        mon_en = 1'b1;

        // digit 0: 717/414 half-periods, full tone+gap+done
        digit = 4'b0000; digit_valid = 1'b1; a = cyc + 1;
        plan(a, 4'b0000, a + T, 0);
        step();
        digit_valid = 1'b0;
        check("d0_ready_low", int'(digit_ready), 0);
        check("d0_busy_high", int'(busy), 1);
        run_to(a + T + 100);
        check("d0_gap_silent", int'({row_tone, col_tone}), 0);
        run_to(a + T + G);
        check("d0_done", int'(done), 1);
        check("d0_ready_at_done", int'(digit_ready), 1);
        step();
        check("d0_done_one_cycle", int'(done), 0);
        queues_empty("d0");

        // abort in IDLE blocks acceptance
        abort = 1'b1; digit_valid = 1'b1;
        step();
        abort = 1'b0; digit_valid = 1'b0;
        check("idle_abort_busy", int'(busy), 0);
        check("idle_abort_ready", int'(digit_ready), 1);
        step();

        // digit F: 531/306 half-periods, busy exactly T+G
        digit = 4'b1111; digit_valid = 1'b1; a = cyc + 1;
        plan(a, 4'b1111, a + T, 0);
        step();
        digit_valid = 1'b0;
        run_to(a + T + G + 3);
        queues_empty("dF");

        // valid held across a sequence: second digit taken on the done cycle's edge
        digit = 4'b0110; digit_valid = 1'b1; a = cyc + 1;
        a2 = a + T + G + 1;
        plan(a, 4'b0110, a + T, 0);
        plan(a2, 4'b1001, a2 + T, 0);
        step();
        digit = 4'b1001;
        run_to(a + T + G);
        check("held_done", int'(done), 1);
        check("held_ready", int'(digit_ready), 1);
        step();
        digit_valid = 1'b0;
        check("held_second_busy", int'(busy), 1);
        check("held_second_ready", int'(digit_ready), 0);
        run_to(a2 + T + G + 3);
        queues_empty("held");

        // abort during TONE
        digit = 4'b1000; digit_valid = 1'b1; a = cyc + 1;
        plan(a, 4'b1000, a + 1600, 1);
        step();
        digit_valid = 1'b0;
        run_to(a + 1599);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(digit_ready), 1);
        check("abort_tones", int'({row_tone, col_tone}), 0);
        check("abort_done", int'(done), 0);
        run_to(a + T + G + 5);
        queues_empty("abort");

        // asynchronous reset mid-tone
        digit = 4'b1010; digit_valid = 1'b1; a = cyc + 1;
        plan(a, 4'b1010, a + 1000, 2);
        step();
        digit_valid = 1'b0;
        run_to(a + 1000);
        check("pre_reset_row", int'(row_tone), 1);
        queues_empty("pre_reset");
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_async_tones", int'({row_tone, col_tone}), 0);
        check("reset_async_busy", int'(busy), 0);
        check("reset_async_done", int'(done), 0);
        check("reset_async_ready", int'(digit_ready), 0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("reset_release_ready", int'(digit_ready), 1);
        check("reset_release_busy", int'(busy), 0);
        mon_en = 1'b1;

        // valid pulsed during GAP is dropped and timing is unchanged
        digit = 4'b0011; digit_valid = 1'b1; a = cyc + 1;
        plan(a, 4'b0011, a + T, 0);
        step();
        digit_valid = 1'b0;
        run_to(a + T + 500);
        digit = 4'b0000; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        check("gap_pulse_ready", int'(digit_ready), 0);
        run_to(a + T + G + 5);
        check("gap_pulse_idle", int'(busy), 0);
        queues_empty("gap_pulse");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtmf_tone_sequencer.md
DTMF_TONE_SEQUENCER -- requirements
Module: dtmf_tone_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 1000000, meaning the inclk frequency in Hz.
REQ-002 The block SHALL have parameter TONE_MS, default 100, meaning the tone-on duration in ms (1..1023).
REQ-003 The block SHALL have parameter GAP_MS, default 50, meaning the inter-digit silence in ms (1..1023).
REQ-004 The block SHALL have port inclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port digit, input, 4 bits: [3:2] selects the row tone and [1:0] selects the column tone.
REQ-007 The block SHALL have port digit_valid, input, 1 bit, meaning a digit is offered.
REQ-008 The block SHALL have port digit_ready, output, 1 bit, meaning the sequencer accepts a digit this cycle.
REQ-009 The block SHALL have port abort, input, 1 bit, a synchronous cancel of the current digit.
REQ-010 The block SHALL have port row_tone, output, 1 bit, the row square wave.
REQ-011 The block SHALL have port col_tone, output, 1 bit, the column square wave.
REQ-012 The block SHALL have port busy, output, 1 bit, high in the TONE and GAP states.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse at the end of the GAP state.

Function
REQ-014 The row half-period counts (in inclk cycles at 1 MHz) SHALL be 717, 649, 587 and 531 for rows 0 to 3 (697, 770, 852 and 941 Hz).
REQ-015 The column half-period counts SHALL be 414, 374, 339 and 306 for columns 0 to 3 (1209, 1336, 1477 and 1633 Hz).
REQ-016 All half-period counts SHALL equal round(CLK_HZ/(2*f)).
REQ-017 The FSM SHALL have the states IDLE, TONE and GAP.
REQ-018 digit_ready SHALL be 1 only in IDLE.
REQ-019 A digit SHALL be accepted on a rising edge where digit_valid and digit_ready are both 1.
REQ-020 On acceptance, the digit SHALL be latched and the FSM SHALL enter TONE on that edge.
REQ-021 digit_valid while busy SHALL be ignored and the digit dropped; the offering side is required to hold it.
REQ-022 On entering TONE, both tone outputs SHALL be 0, and their half-period counters and the ms counter SHALL be cleared.
REQ-023 In TONE, each tone output SHALL toggle every Nhalf cycles of its selected count.
REQ-024 The first toggle SHALL occur Nhalf cycles after TONE entry.
REQ-025 The ms timebase SHALL produce a tick every CLK_HZ/1000 cycles.
REQ-026 TONE SHALL last exactly TONE_MS*CLK_HZ/1000 cycles, after which the FSM enters GAP.
REQ-027 In GAP, row_tone and col_tone SHALL be forced to 0 and the tone counters held at 0.
REQ-028 GAP SHALL last exactly GAP_MS*CLK_HZ/1000 cycles.
REQ-029 At the end of GAP, the FSM SHALL return to IDLE and done SHALL pulse 1 for exactly one cycle.
REQ-030 A digit offered on the done cycle SHALL be accepted on the next edge, since ready is already 1 in IDLE.
REQ-031 abort=1 in TONE or GAP SHALL force IDLE on the next edge, with tones at 0, done not pulsed, and all counters cleared.
REQ-032 abort SHALL have priority over the timer expiry in the same cycle.
REQ-033 abort=1 in IDLE SHALL block acceptance in that cycle.
REQ-034 The ms counter and the tone counters SHALL wrap to 0 at their terminal count with no off-by-one.

Reset
REQ-035 While rst_n=0, the FSM SHALL be IDLE and all counters and the latched digit SHALL be 0.
REQ-036 While rst_n=0, row_tone, col_tone, busy and done SHALL be 0, and digit_ready SHALL be 0.
REQ-037 digit_ready SHALL rise on the first inclk edge after rst_n deasserts.
REQ-038 A reset mid-tone SHALL silence the outputs immediately (asynchronously) and no done SHALL be produced.

Structure
REQ-039 The half-period table, the state encoding and the ms divisor SHALL reside in the shared package dtmf_pkg.
REQ-040 One sub-module, dtmf_tone_gen, SHALL be instantiated twice (row and column): it takes a loadable half-period, an enable and a clear, and outputs a square wave.

Verification
REQ-041 The bench SHALL check: digit=4'b0000 accepted at t0 -> row_tone toggles every 717 cycles and col_tone every 414 cycles for 100000 cycles, then both 0 for 50000 cycles, then one done pulse.
REQ-042 The bench SHALL check: digit=4'b1111 -> half-periods of 531 and 306 cycles, with busy high for exactly 150000 cycles.
REQ-043 The bench SHALL check: digit_valid held through a full sequence -> the second digit is accepted on the cycle after done, with no idle gap.
REQ-044 The bench SHALL check: abort at TONE cycle 40000 -> IDLE next edge, tones 0, no done, and digit_ready=1.
REQ-045 The bench SHALL check: rst_n low at TONE cycle 10000 -> all outputs 0 immediately, and ready=1 on the first edge after release.
REQ-046 The bench SHALL check: digit_valid pulsed during GAP -> the pulse is ignored and the sequence timing is unchanged.
